// File: rtl/ps_ureg_pkg.sv
// ps_ureg_pkg: shared group codes, stack-top default and write-back stage record
// for the ureg decoder pipe.
package ps_ureg_pkg;
  localparam logic [3:0] GRP_XB  = 4'h0;
  localparam logic [3:0] GRP_DG1 = 4'h1;
  localparam logic [3:0] GRP_DG2 = 4'h2;
  localparam logic [3:0] GRP_PS6 = 4'h6;
  localparam logic [3:0] GRP_PS7 = 4'h7;
  localparam logic [4:0] STK_ADD_DEF = 5'h04;
  // Stage addresses are carried at a fixed maximum width so the record is parameter independent
  localparam int WB_AW = 8;
  typedef struct packed {
    logic en_xb;
    logic en_dg;
    logic en_ps;
    logic [WB_AW-1:0] dg_add;
    logic [WB_AW-1:0] ps_add;
  } wb_stage_t;
endpackage

// File: rtl/ps_ureg_grp_dcd.sv
// ps_ureg_grp_dcd: pure ureg group decoder, ureg -> one-hot target and local addresses
// (addresses are 0 when the target is not hit).
module ps_ureg_grp_dcd
  import ps_ureg_pkg::*;
#(
  parameter int UREG_AW = 8,
  parameter int XB_AW   = 4,
  parameter int RF_AW   = 5
) (
  input  logic [UREG_AW-1:0] ureg,
  input  logic               vld,
  output logic               hit_xb,
  output logic               hit_dg,
  output logic               hit_ps,
  output logic [XB_AW-1:0]   xb_add,
  output logic [RF_AW-1:0]   dg_add,
  output logic [RF_AW-1:0]   ps_add
);
  logic [3:0] grp;
  assign grp    = ureg[UREG_AW-1 -: 4];
  assign hit_xb = vld & (grp == GRP_XB);
  assign hit_dg = vld & ((grp == GRP_DG1) | (grp == GRP_DG2));
  assign hit_ps = vld & ((grp == GRP_PS6) | (grp == GRP_PS7));
  assign xb_add = hit_xb ? ureg[XB_AW-1:0] : '0;
  assign dg_add = hit_dg ? ureg[RF_AW-1:0] : '0;
  assign ps_add = hit_ps ? ureg[RF_AW-1:0] : '0;
endmodule

// File: rtl/ps_ureg_dcd_pipe.sv
// ps_ureg_dcd_pipe: ureg read/write decoder with WB_LAT-deep write-back pipe, PC stack tracking.
// Build option PS_UREG_HZD_EN: adds read-after-write stall comparators (else stall tied 0).
module ps_ureg_dcd_pipe
  import ps_ureg_pkg::*;
#(
  parameter int UREG_AW   = 8,
  parameter int XB_AW     = 4,
  parameter int RF_AW     = 5,
  parameter int WB_LAT    = 1,
  parameter int STK_DEPTH = 8,
  parameter logic [RF_AW-1:0] STK_ADD = RF_AW'(STK_ADD_DEF),
  localparam int LW = $clog2(STK_DEPTH+1)
) (
  input  logic               clk_dcd,
  input  logic               rst_dcd_n,
  input  logic               ps_pshstck,
  input  logic               ps_popstck,
  input  logic               ps_imminst,
  input  logic               ps_dminst,
  input  logic               ps_dmiaddinst,
  input  logic               ps_urgtrnsinst,
  input  logic               ps_loop,
  input  logic               ps_dm_wrb,
  input  logic [UREG_AW-1:0] ps_ureg1_add,
  input  logic [UREG_AW-1:0] ps_ureg2_add,
  output logic [XB_AW-1:0]   ps_xb_dm_rd_add,
  output logic [RF_AW-1:0]   ps_dg_rd_add,
  output logic [RF_AW-1:0]   ps_rd_add,
  output logic [XB_AW-1:0]   ps_xb_dm_wrt_add,
  output logic               ps_xb_w_bcEn,
  output logic               ps_dg_wrt_en,
  output logic [RF_AW-1:0]   ps_dg_wrt_add,
  output logic               ps_wrt_en,
  output logic [RF_AW-1:0]   ps_wrt_add,
  output logic [LW-1:0]      ps_stk_lvl,
  output logic               ps_stk_ovf,
  output logic               ps_stk_unf,
  output logic               ps_dcd_stall
);
  logic rd_u1, rd_vld, wr_cls, full, empty, pop_rd, psh_wr;
  logic [UREG_AW-1:0] rd_ureg;
  logic r_xb, r_dg, r_ps, w_xb, w_dg, w_ps;
  logic [XB_AW-1:0] r_xb_add, w_xb_add;
  logic [RF_AW-1:0] r_dg_add, r_ps_add, w_dg_add, w_ps_add;
  wb_stage_t nxt;
  wb_stage_t pipe [WB_LAT];
  assign full    = ps_stk_lvl == LW'(STK_DEPTH);
  assign empty   = ps_stk_lvl == '0;
  assign rd_u1   = ps_pshstck | ps_loop | ((ps_dminst | ps_dmiaddinst) & ps_dm_wrb);
  assign rd_vld  = rd_u1 | ps_urgtrnsinst;
  assign rd_ureg = rd_u1 ? ps_ureg1_add : ps_ureg2_add;
  assign wr_cls  = ps_popstck | ps_imminst | ps_urgtrnsinst | ((ps_dminst | ps_dmiaddinst) & ~ps_dm_wrb);
  assign pop_rd  = ~rd_vld & ps_popstck & ~empty;
  assign psh_wr  = ~wr_cls & ps_pshstck & ~full;
  ps_ureg_grp_dcd #(.UREG_AW(UREG_AW), .XB_AW(XB_AW), .RF_AW(RF_AW)) u_rd (
    .ureg(rd_ureg), .vld(rd_vld), .hit_xb(r_xb), .hit_dg(r_dg), .hit_ps(r_ps),
    .xb_add(r_xb_add), .dg_add(r_dg_add), .ps_add(r_ps_add)
  );
  ps_ureg_grp_dcd #(.UREG_AW(UREG_AW), .XB_AW(XB_AW), .RF_AW(RF_AW)) u_wr (
    .ureg(ps_ureg1_add), .vld(wr_cls), .hit_xb(w_xb), .hit_dg(w_dg), .hit_ps(w_ps),
    .xb_add(w_xb_add), .dg_add(w_dg_add), .ps_add(w_ps_add)
  );
  assign ps_xb_dm_rd_add  = r_xb_add;
  assign ps_dg_rd_add     = r_dg_add;
  assign ps_rd_add        = pop_rd ? STK_ADD : r_ps_add;
  assign ps_xb_dm_wrt_add = w_xb_add;
  always_comb begin
    nxt.en_xb  = w_xb;
    nxt.en_dg  = w_dg;
    nxt.en_ps  = w_ps | psh_wr;
    nxt.dg_add = WB_AW'(w_dg_add);
    nxt.ps_add = psh_wr ? WB_AW'(STK_ADD) : WB_AW'(w_ps_add);
  end
  always_ff @(posedge clk_dcd or negedge rst_dcd_n) begin
    if (!rst_dcd_n) begin
      for (int i = 0; i < WB_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= nxt;
      for (int i = 1; i < WB_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign ps_xb_w_bcEn  = pipe[WB_LAT-1].en_xb;
  assign ps_dg_wrt_en  = pipe[WB_LAT-1].en_dg;
  assign ps_dg_wrt_add = pipe[WB_LAT-1].dg_add[RF_AW-1:0];
  assign ps_wrt_en     = pipe[WB_LAT-1].en_ps;
  assign ps_wrt_add    = pipe[WB_LAT-1].ps_add[RF_AW-1:0];
  // Simultaneous push and pop cancel: level unchanged and no flag
  always_ff @(posedge clk_dcd or negedge rst_dcd_n) begin
    if (!rst_dcd_n) begin
      ps_stk_lvl <= '0;
      ps_stk_ovf <= 1'b0;
      ps_stk_unf <= 1'b0;
    end else if (ps_pshstck & ~ps_popstck) begin
      ps_stk_lvl <= full ? ps_stk_lvl : ps_stk_lvl + 1'b1;
      ps_stk_ovf <= ps_stk_ovf | full;
    end else if (ps_popstck & ~ps_pshstck) begin
      ps_stk_lvl <= empty ? ps_stk_lvl : ps_stk_lvl - 1'b1;
      ps_stk_unf <= ps_stk_unf | empty;
    end
  end
`ifdef PS_UREG_HZD_EN
  logic ps_rd_vld;
  assign ps_rd_vld = r_ps | pop_rd;
  always_comb begin
    ps_dcd_stall = 1'b0;
    for (int i = 0; i < WB_LAT; i++)
      ps_dcd_stall = ps_dcd_stall
        | (r_dg & pipe[i].en_dg & (pipe[i].dg_add == WB_AW'(ps_dg_rd_add)))
        | (ps_rd_vld & pipe[i].en_ps & (pipe[i].ps_add == WB_AW'(ps_rd_add)));
  end
`else
  assign ps_dcd_stall = 1'b0;
`endif
endmodule
